// File: rtl/exstage.sv
// exstage: execute stage -- ALU, optional 32-cycle restoring divider, data-SRAM request, EX->MA handshake.
// Ports: clk/resetn (async active-low); id_validout, id_to_ex_bus[150:0] from ID; ma_allowin from MA;
//   ex_allowin, ex_validout, ex_to_ma_bus[70:0], ex_to_id_dest[4:0] to the pipeline;
//   data_sram_en/we/addr/wdata to the data SRAM.
// Build option: define EX_DIV_EN to compile in the divider; otherwise a divide bundle yields 0 in one cycle.
module exstage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         id_validout,
  input  logic         ma_allowin,
  output logic         ex_allowin,
  output logic         ex_validout,
  input  logic [150:0] id_to_ex_bus,
  output logic [70:0]  ex_to_ma_bus,
  output logic [4:0]   ex_to_id_dest,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);
  logic         valid;
  logic         readygo;
  logic [150:0] bus;
  logic         is_div, sgn, want_rem, res_from_mem, gr_we, mem_we;
  logic [11:0]  alu_op;
  logic [31:0]  src1, src2, rkd_value, pc, alu_result, ex_result;
  logic [4:0]   dest;
  assign {is_div, sgn, want_rem} = bus[150:148];
  assign alu_op       = bus[147:136];
  assign src1         = bus[135:104];
  assign src2         = bus[103:72];
  assign res_from_mem = bus[71];
  assign gr_we        = bus[70];
  assign mem_we       = bus[69];
  assign dest         = bus[68:64];
  assign rkd_value    = bus[63:32];
  assign pc           = bus[31:0];
  assign ex_allowin  = ~valid | (readygo & ma_allowin);
  assign ex_validout = valid & readygo;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid <= 1'b0;
      bus   <= '0;
    end else begin
      if (ex_allowin) valid <= id_validout;
      if (id_validout & ex_allowin) bus <= id_to_ex_bus;
    end
  logic [31:0] add_r, sub_r;
  assign add_r = src1 + src2;
  assign sub_r = src1 - src2;
  assign alu_result = ({32{alu_op[0]}}  & add_r)
                    | ({32{alu_op[1]}}  & sub_r)
                    | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
                    | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
                    | ({32{alu_op[4]}}  & (src1 & src2))
                    | ({32{alu_op[5]}}  & ~(src1 | src2))
                    | ({32{alu_op[6]}}  & (src1 | src2))
                    | ({32{alu_op[7]}}  & (src1 ^ src2))
                    | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                    | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                    | ({32{alu_op[10]}} & 32'($signed(src1) >>> src2[4:0]))
                    | ({32{alu_op[11]}} & src2);
`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  // q starts as |dividend| and shifts left, collecting quotient bits in its LSBs
  logic [31:0] q, d, r, rd, quo, rem;
  logic [32:0] rs;
  logic        ge, div0, neg_q, neg_r;
  assign rs    = {r, q[31]};
  assign ge    = rs >= {1'b0, d};
  // the true difference always fits in 32 bits when ge, so modular subtraction is exact
  assign rd    = rs[31:0] - d;
  assign div0  = src2 == 32'd0;
  assign neg_q = sgn & (src1[31] ^ src2[31]);
  assign neg_r = sgn & src1[31];
  assign quo   = div0 ? 32'd0 : neg_q ? -q : q;
  assign rem   = div0 ? src1 : neg_r ? -r : r;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      d     <= '0;
      r     <= '0;
    end else
      case (state)
        IDLE: if (valid & is_div) begin
          state <= BUSY;
          q     <= (sgn & src1[31]) ? -src1 : src1;
          d     <= (sgn & src2[31]) ? -src2 : src2;
          r     <= '0;
          cnt   <= '0;
        end
        BUSY: begin
          r     <= ge ? rd : rs[31:0];
          q     <= {q[30:0], ge};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: if (ex_validout & ma_allowin) state <= IDLE;
        default: state <= IDLE;
      endcase
  assign readygo   = ~(valid & is_div) | (state == DONE);
  assign ex_result = is_div ? (want_rem ? rem : quo) : alu_result;
`else
  logic unused_div_flags;
  assign unused_div_flags = &{1'b0, sgn, want_rem};
  assign readygo   = 1'b1;
  assign ex_result = is_div ? 32'd0 : alu_result;
`endif
  assign ex_to_ma_bus    = {res_from_mem, gr_we, dest, ex_result, pc};
  assign ex_to_id_dest   = dest & {5{valid}};
  // request fires only on the handoff cycle, so a stalled store issues exactly once
  assign data_sram_en    = valid & readygo & ma_allowin & (res_from_mem | mem_we);
  assign data_sram_we    = {4{data_sram_en & mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;
endmodule

// File: tb/tb_exstage.sv
// tb_exstage: directed self-checking bench for exstage.
module tb_exstage;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         id_validout = 1'b0;
  logic         ma_allowin = 1'b1;
  logic [150:0] id_to_ex_bus = '0;
  logic         ex_allowin, ex_validout, data_sram_en;
  logic [70:0]  ex_to_ma_bus;
  logic [4:0]   ex_to_id_dest;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [11:0] ADD = 12'h001, SUB = 12'h002, SLT = 12'h004, SLTU = 12'h008,
                          AND = 12'h010, NOR = 12'h020, OR = 12'h040, XOR = 12'h080,
                          SLL = 12'h100, SRL = 12'h200, SRA = 12'h400, LUI = 12'h800;
  exstage dut (
    .clk(clk), .resetn(resetn), .id_validout(id_validout), .ma_allowin(ma_allowin),
    .ex_allowin(ex_allowin), .ex_validout(ex_validout), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_ma_bus(ex_to_ma_bus), .ex_to_id_dest(ex_to_id_dest), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [150:0] mk(input logic [2:0] dop, input logic [11:0] aop,
      input logic [31:0] a, input logic [31:0] b, input logic rfm, input logic gwe,
      input logic mwe, input logic [4:0] dst, input logic [31:0] rkd, input logic [31:0] pc);
    return {dop, aop, a, b, rfm, gwe, mwe, dst, rkd, pc};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // drive a bundle and return 1ns into the cycle in which it is latched
  task automatic issue(input logic [150:0] b);
    id_validout  = 1'b1;
    id_to_ex_bus = b;
    tick();
    id_validout  = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, " validout"}, ex_validout, 0);
    chk({tag, " allowin"}, ex_allowin, 1);
    chk({tag, " sram_en"}, data_sram_en, 0);
    chk({tag, " sram_we"}, data_sram_we, 0);
    chk({tag, " dest"}, ex_to_id_dest, 0);
    chk({tag, " bus"}, ex_to_ma_bus, 0);
  endtask
  task automatic alu(input string tag, input logic [11:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] exp);
    issue(mk(3'b000, op, a, b, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h100));
    chk({tag, " valid"}, ex_validout, 1);
    chk({tag, " result"}, ex_to_ma_bus[63:32], exp);
    chk({tag, " sram_en"}, data_sram_en, 0);
    tick();
  endtask
`ifdef EX_DIV_EN
  task automatic run_div(input string tag, input logic sgn, input logic rm, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] exp, input logic stall);
    issue(mk({1'b1, sgn, rm}, 12'h0, a, b, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'h200));
    for (int i = 0; i < 33; i++) begin
      chk({tag, " busy validout"}, ex_validout, 0);
      chk({tag, " busy allowin"}, ex_allowin, 0);
      if (i < 32) tick();
    end
    tick();
    chk({tag, " done validout"}, ex_validout, 1);
    chk({tag, " result"}, ex_to_ma_bus[63:32], exp);
    if (stall) begin
      ma_allowin = 1'b0;
      tick();
      tick();
      chk({tag, " stall validout"}, ex_validout, 1);
      chk({tag, " stall result"}, ex_to_ma_bus[63:32], exp);
      chk({tag, " stall allowin"}, ex_allowin, 0);
      ma_allowin = 1'b1;
      #1;
    end
    tick();
    chk({tag, " after handoff"}, ex_validout, 0);
  endtask
`endif
  initial begin
    #2;
    check_reset_outputs("reset_async");
    #10;
    check_reset_outputs("reset_held");
    @(negedge clk);
    resetn = 1'b1;
    issue(mk(3'b000, ADD, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h100));
    chk("add valid", ex_validout, 1);
    chk("add result", ex_to_ma_bus[63:32], 32'h0000000C);
    chk("add sram_en", data_sram_en, 0);
    chk("add dest", ex_to_id_dest, 5'd3);
    chk("add pc", ex_to_ma_bus[31:0], 32'h100);
    chk("add gr_we", ex_to_ma_bus[69], 1);
    tick();
    chk("add drained", ex_validout, 0);
    alu("sub", SUB, 32'd5, 32'd7, 32'hFFFFFFFE);
    alu("slt", SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu("sltu", SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu("and", AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    alu("nor", NOR, 32'h0F0F0F0F, 32'hF0F0F000, 32'h000000F0);
    alu("or", OR, 32'h12340000, 32'h00005678, 32'h12345678);
    alu("xor", XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00);
    alu("sll", SLL, 32'd1, 32'h0000003F, 32'h80000000);
    alu("srl", SRL, 32'h80000000, 32'd4, 32'h08000000);
    alu("sra", SRA, 32'h80000000, 32'd4, 32'hF8000000);
    alu("lui", LUI, 32'hDEADBEEF, 32'h12345000, 32'h12345000);
    ma_allowin = 1'b0;
    issue(mk(3'b000, ADD, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hA5A5A5A5, 32'h300));
    chk("st c0 valid", ex_validout, 1);
    chk("st c0 allowin", ex_allowin, 0);
    chk("st c0 en", data_sram_en, 0);
    chk("st c0 we", data_sram_we, 0);
    tick();
    chk("st c1 en", data_sram_en, 0);
    tick();
    chk("st c2 en", data_sram_en, 0);
    tick();
    ma_allowin = 1'b1;
    #1;
    chk("st fire en", data_sram_en, 1);
    chk("st fire we", data_sram_we, 4'hF);
    chk("st fire addr", data_sram_addr, 32'h1000);
    chk("st fire wdata", data_sram_wdata, 32'hA5A5A5A5);
    tick();
    chk("st after en", data_sram_en, 0);
    chk("st after we", data_sram_we, 0);
    chk("st after valid", ex_validout, 0);
    issue(mk(3'b000, ADD, 32'h2000, 32'd4, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h400));
    chk("ld en", data_sram_en, 1);
    chk("ld we", data_sram_we, 0);
    chk("ld addr", data_sram_addr, 32'h2004);
    chk("ld res_from_mem", ex_to_ma_bus[70], 1);
    tick();
    chk("ld after en", data_sram_en, 0);
    ma_allowin = 1'b0;
    issue(mk(3'b000, ADD, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0, 32'h500));
    chk("hold dest", ex_to_id_dest, 5'd6);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_hold");
    @(negedge clk);
    resetn = 1'b1;
    ma_allowin = 1'b1;
`ifdef EX_DIV_EN
    run_div("div_s_quo", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1);
    run_div("div_s_rem", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    run_div("div_u_quo", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 1'b0);
    run_div("div_u_rem", 1'b0, 1'b1, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 1'b0);
    run_div("div0_quo", 1'b0, 1'b0, 32'd100, 32'd0, 32'd0, 1'b0);
    run_div("div0_rem", 1'b0, 1'b1, 32'd100, 32'd0, 32'd100, 1'b0);
    run_div("ovf_quo", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_div("ovf_rem", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    issue(mk(3'b110, 12'h0, 32'd1000, 32'd3, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'h600));
    for (int i = 0; i < 11; i++) tick();
    chk("rst_busy allowin", ex_allowin, 0);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_div");
    @(negedge clk);
    resetn = 1'b1;
`else
    issue(mk(3'b110, 12'h0, 32'd100, 32'd3, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'h600));
    chk("nodiv valid", ex_validout, 1);
    chk("nodiv result", ex_to_ma_bus[63:32], 32'h0);
    chk("nodiv allowin", ex_allowin, 1);
    tick();
`endif
    issue(mk(3'b000, ADD, 32'h10, 32'h20, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 32'h700));
    chk("post_rst valid", ex_validout, 1);
    chk("post_rst result", ex_to_ma_bus[63:32], 32'h30);
    chk("post_rst dest", ex_to_id_dest, 5'd4);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
